// File: rtl/sim_mem_mmio_pkg.sv
// Shared constants for the simulation memory/MMIO block: register offsets inside
// the 32-byte MMIO window and the ebreak encoding watched on the fetch port.
package sim_mmio_pkg;

    localparam logic [4:0] CON_OFF    = 5'h04;
    localparam logic [4:0] EXIT_OFF   = 5'h08;
    localparam logic [4:0] CYC_LO_OFF = 5'h0C;
    localparam logic [4:0] CYC_HI_OFF = 5'h10;
    localparam logic [4:0] INS_LO_OFF = 5'h14;
    localparam logic [4:0] INS_HI_OFF = 5'h18;
    localparam logic [4:0] STAT_OFF   = 5'h1C;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/sim_mem_mmio_fifo.sv
// Synchronous FIFO used as the console buffer; head data is read combinationally
// so it stays stable until popped. Storage is not reset, only the pointers.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sim_mem_mmio.sv
// Unified RAM + MMIO device for simulation. Define MMIO_READBACK_EN to make MMIO
// reads return register values; by default they return 0.
module sim_mem_mmio
    import sim_mmio_pkg::*;
#(
    parameter int          MEM_WORDS = 32768,
    parameter logic [31:0] MMIO_BASE = 32'h0002_0000,
    parameter int          READ_LAT  = 1,
    parameter int          CON_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_write,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        con_overflow,
    output logic [7:0]  ebreak_count,
    output logic [63:0] cycle_count,
    output logic [63:0] instr_count,
    output logic        done,
    output logic [31:0] done_code
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(CON_DEPTH) + 1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [31:0]   ram_q [MEM_WORDS];
    logic [IW-1:0] d_idx, f_idx;
    logic [4:0]    off;
    logic          hit, wr_any;

    logic          con_ovf_q, done_q;
    logic [7:0]    ebreak_q;
    logic [63:0]   cyc_q, ins_q;
    logic [31:0]   code_q;
    logic [31:0]   rd_q [READ_LAT];
    logic [31:0]   rd_d, mmio_rd;

    logic          con_push, con_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;

    assign hit    = (mem_addr[31:5] == MMIO_BASE[31:5]);
    assign off    = mem_addr[4:0];
    assign wr_any = |mem_write;
    assign d_idx  = mem_addr[IW+1:2];
    assign f_idx  = pc[IW+1:2];
    assign instr  = ram_q[f_idx];

    // RAM: byte lanes, never touched by MMIO hits
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!hit && mem_write[k]) ram_q[d_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    assign con_push = hit && wr_any && (off == CON_OFF);
    assign con_pop  = con_ready && !fifo_empty;

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (CON_DEPTH)
    ) u_con_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (con_push),
        .data_i  (mem_wdata[7:0]),
        .pop_i   (con_pop),
        .data_o  (con_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // MMIO register file
    always_ff @(posedge clk) begin
        if (reset) begin
            con_ovf_q <= 1'b0;
            ebreak_q  <= '0;
            cyc_q     <= '0;
            ins_q     <= '0;
            done_q    <= 1'b0;
            code_q    <= '0;
        end else begin
            if (con_push && fifo_full && !con_pop) con_ovf_q <= 1'b1;
            if (instr == EBREAK_INSN) ebreak_q <= sat_inc8(ebreak_q);
            if (hit && wr_any) begin
                case (off)
                    EXIT_OFF: begin
                        if (!done_q) begin
                            done_q <= 1'b1;
                            code_q <= mem_wdata;
                        end
                    end
                    CYC_LO_OFF: cyc_q[31:0]  <= mem_wdata;
                    CYC_HI_OFF: cyc_q[63:32] <= mem_wdata;
                    INS_LO_OFF: ins_q[31:0]  <= mem_wdata;
                    INS_HI_OFF: ins_q[63:32] <= mem_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef MMIO_READBACK_EN
    always_comb begin
        mmio_rd = '0;
        case (off)
            CON_OFF:    mmio_rd = {23'b0, con_ovf_q, 8'(fifo_cnt)};
            EXIT_OFF:   mmio_rd = code_q;
            CYC_LO_OFF: mmio_rd = cyc_q[31:0];
            CYC_HI_OFF: mmio_rd = cyc_q[63:32];
            INS_LO_OFF: mmio_rd = ins_q[31:0];
            INS_HI_OFF: mmio_rd = ins_q[63:32];
            STAT_OFF:   mmio_rd = {24'b0, ebreak_q};
            default:    mmio_rd = '0;
        endcase
    end
`else
    assign mmio_rd = '0;
`endif

    assign rd_d = hit ? mmio_rd : ram_q[d_idx];

    // Read pipeline: stage 0 samples RAM before this edge's write lands
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LAT; i++) rd_q[i] <= '0;
        end else begin
            rd_q[0] <= rd_d;
            for (int i = 1; i < READ_LAT; i++) rd_q[i] <= rd_q[i-1];
        end
    end

    assign mem_rdata    = rd_q[READ_LAT-1];
    assign con_valid    = !fifo_empty;
    assign con_overflow = con_ovf_q;
    assign ebreak_count = ebreak_q;
    assign cycle_count  = cyc_q;
    assign instr_count  = ins_q;
    assign done         = done_q;
    assign done_code    = code_q;

    logic unused_bits;
    assign unused_bits = ^{pc[31:IW+2], pc[1:0], mem_addr[31:IW+2], fifo_cnt};

endmodule

// File: tb/tb_sim_mem_mmio.sv
// Directed bench for sim_mem_mmio: a RAM/fetch vector table plus hand-written
// sequences for console FIFO, counters, exit, ebreak and mid-stream reset.
module tb_sim_mem_mmio;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h100;
    logic [31:0] instr;
    logic [31:0] mem_addr = '0;
    logic [3:0]  mem_write = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b1;
    logic        con_overflow;
    logic [7:0]  ebreak_count;
    logic [63:0] cycle_count;
    logic [63:0] instr_count;
    logic        done;
    logic [31:0] done_code;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sim_mem_mmio #(
        .MEM_WORDS (32768),
        .MMIO_BASE (32'h0002_0000),
        .READ_LAT  (LAT),
        .CON_DEPTH (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instr        (instr),
        .mem_addr     (mem_addr),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .con_valid    (con_valid),
        .con_data     (con_data),
        .con_ready    (con_ready),
        .con_overflow (con_overflow),
        .ebreak_count (ebreak_count),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count),
        .done         (done),
        .done_code    (done_code)
    );

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[10];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        mem_addr  = a;
        mem_write = be;
        mem_wdata = d;
        tick();
        mem_write = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdata"}, mem_rdata, 0);
        chk({tag, "_con_valid"}, con_valid, 0);
        chk({tag, "_con_ovf"}, con_overflow, 0);
        chk({tag, "_ebreak"}, ebreak_count, 0);
        chk({tag, "_cycle"}, cycle_count, 0);
        chk({tag, "_instr_cnt"}, instr_count, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_done_code"}, done_code, 0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0100, 4'b0100, 32'h0011_0000, 32'h0000_0100, 32'hDE11_BEEF, 32'hDE11_BEEF};
        vecs[2] = '{32'h0000_0004, 4'hF, 32'h1234_5678, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{32'h0002_0004, 4'hF, 32'h0000_0041, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678};
        vecs[4] = '{32'h0001_FFFC, 4'hF, 32'hCAFE_F00D, 32'h0003_FFFC, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[5] = '{32'h0000_0008, 4'hF, 32'h1122_3344, 32'h0000_0008, 32'h1122_3344, 32'h1122_3344};
        vecs[6] = '{32'h0000_0008, 4'b1000, 32'h9900_0000, 32'h0000_0008, 32'h9922_3344, 32'h9922_3344};
        vecs[7] = '{32'h0000_0008, 4'b0011, 32'hFFFF_5566, 32'h0000_0008, 32'h9922_5566, 32'h9922_5566};
        vecs[8] = '{32'h0000_0000, 4'hF, 32'h0BAD_F00D, 32'h0000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D};
        vecs[9] = '{32'h0002_0000, 4'hF, 32'hFFFF_FFFF, 32'h0002_0000, 32'h0000_0000, 32'h0BAD_F00D};

        tick(2);
        chk_reset_outputs("reset");
        reset = 1'b0;

        // RAM / fetch vector table
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].waddr, vecs[i].be, vecs[i].wdata);
            mem_addr = vecs[i].raddr;
            pc       = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
            tick(LAT);
            chk($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rd);
        end

        // Read and write of the same word in one cycle returns the old data
        pc = 32'h100;
        mem_addr = 32'h100; mem_write = 4'hF; mem_wdata = 32'h5555_5555;
        tick();
        mem_write = '0;
        tick(LAT - 1);
        chk("raw_old", mem_rdata, 32'hDE11_BEEF);
        tick();
        chk("raw_new", mem_rdata, 32'h5555_5555);

        // Console overflow then ordered drain
        reset = 1'b1; tick(); reset = 1'b0;
        con_ready = 1'b0;
        mem_addr = 32'h0002_0004; mem_write = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            mem_wdata = i;
            tick();
        end
        chk("fifo16_ovf", con_overflow, 0);
        chk("fifo16_valid", con_valid, 1);
        mem_wdata = 32'd16;
        tick();
        mem_write = '0; mem_addr = 32'h100;
        chk("fifo17_ovf", con_overflow, 1);
        con_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), con_valid, 1);
            chk($sformatf("drain%0d_data", i), con_data, i);
            tick();
        end
        chk("drain_empty", con_valid, 0);
        chk("drain_ovf_sticky", con_overflow, 1);

        // Full FIFO with simultaneous push and pop
        reset = 1'b1; tick(); reset = 1'b0;
        con_ready = 1'b0;
        mem_addr = 32'h0002_0004; mem_write = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            mem_wdata = i;
            tick();
        end
        con_ready = 1'b1; mem_wdata = 32'hEE;
        tick();
        mem_write = '0; mem_addr = 32'h100;
        chk("pushpop_ovf", con_overflow, 0);
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("pp%0d_data", j), con_data, (j < 15) ? j + 1 : 32'hEE);
            tick();
        end
        chk("pp_empty", con_valid, 0);

        // Counter capture and exit register
        wr(32'h0002_000C, 4'hF, 32'd5);
        wr(32'h0002_0010, 4'hF, 32'd1);
        wr(32'h0002_0014, 4'b0001, 32'hA5A5_A5A5);
        chk("cycle_count", cycle_count, 64'h1_0000_0005);
        chk("instr_count", instr_count, 64'h0_A5A5_A5A5);
        chk("done_before", done, 0);
        wr(32'h0002_0008, 4'hF, 32'd0);
        chk("done_first", done, 1);
        chk("code_first", done_code, 0);
        wr(32'h0002_0008, 4'hF, 32'd7);
        chk("done_second", done, 1);
        chk("code_second", done_code, 0);

        // Ebreak counting and saturation
        wr(32'h0000_0200, 4'hF, 32'h0010_0073);
        pc = 32'h200;
        tick(10);
        chk("ebreak10", ebreak_count, 10);
        tick(290);
        chk("ebreak_sat", ebreak_count, 255);

        mem_addr = 32'h0002_001C;
        tick(LAT);
`ifdef MMIO_READBACK_EN
        chk("rb_stat", mem_rdata, 255);
`else
        chk("rb_stat", mem_rdata, 0);
`endif
        mem_addr = 32'h0002_000C;
        tick(LAT);
`ifdef MMIO_READBACK_EN
        chk("rb_cyc_lo", mem_rdata, 5);
`else
        chk("rb_cyc_lo", mem_rdata, 0);
`endif

        // Reset mid-stream clears everything on the next cycle
        reset = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        reset = 1'b0;
        tick();
        chk("ebreak_after_reset", ebreak_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
